// File: rtl/acm_lut_pkg.sv
// Shared definitions for the ACM lookup-table engine: FSM state encoding and
// the fill value returned on a lookup miss.
package acm_lut_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_READ = 2'd2,
        ST_RESP = 2'd3
    } lut_state_t;

    // Every LK_DATA bit takes this value on a miss or when no ack is pending.
    localparam logic MISS_BIT = 1'b0;

endpackage

// File: rtl/acm_lut_if.sv
// Lookup / write / status bundle for acm_lut_engine.
// PAR_ERR exists only when ACM_LUT_PARITY_EN is defined.
interface acm_lut_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);

    logic                  LK_REQ;
    logic [ADDR_WIDTH-1:0] LK_ADDR;
    logic                  LK_ACK;
    logic [DATA_WIDTH-1:0] LK_DATA;
    logic                  LK_HIT;
    logic                  WR_EN;
    logic [ADDR_WIDTH-1:0] WR_ADDR;
    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  WR_VALID;
    logic                  INIT_BUSY;
`ifdef ACM_LUT_PARITY_EN
    logic                  PAR_ERR;
`endif

    modport slave (
        input  LK_REQ, LK_ADDR, WR_EN, WR_ADDR, WR_DATA, WR_VALID,
        output LK_ACK, LK_DATA, LK_HIT, INIT_BUSY
`ifdef ACM_LUT_PARITY_EN
        , output PAR_ERR
`endif
    );

    modport master (
        output LK_REQ, LK_ADDR, WR_EN, WR_ADDR, WR_DATA, WR_VALID,
        input  LK_ACK, LK_DATA, LK_HIT, INIT_BUSY
`ifdef ACM_LUT_PARITY_EN
        , input PAR_ERR
`endif
    );

endinterface

// File: rtl/acm_lut_ram.sv
// Table storage: one write port, one synchronous read port with write-first
// bypass so a same-address write in the read cycle returns the new entry.
module acm_lut_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int ENTRY_W    = 9
) (
    input  logic                  PCLK,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [ENTRY_W-1:0]    wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [ENTRY_W-1:0]    rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]   widx;
    logic [IDX_W-1:0]   ridx;

    // Callers only present in-range addresses; the low bits index the array.
    assign widx = waddr[IDX_W-1:0];
    assign ridx = raddr[IDX_W-1:0];

    always_ff @(posedge PCLK) begin
        if (we) begin
            mem[widx] <= wdata;
        end
        if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[ridx];
        end
    end

endmodule

// File: rtl/acm_lut_engine.sv
// Lookup-table engine: clears the table after reset, then serves 2-cycle
// lookups and single-cycle writes. Optional parity: ACM_LUT_PARITY_EN.
module acm_lut_engine
    import acm_lut_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic      PCLK,
    input  logic      NSYSRESET,
    acm_lut_if.slave  bus
);

`ifdef ACM_LUT_PARITY_EN
    localparam int ENTRY_W = DATA_WIDTH + 2;
`else
    localparam int ENTRY_W = DATA_WIDTH + 1;
`endif
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] MISS_DATA = {DATA_WIDTH{MISS_BIT}};

    lut_state_t            state;
    lut_state_t            state_nxt;
    logic [ADDR_WIDTH-1:0] clr_cnt;

    logic [ADDR_WIDTH-1:0] lk_addr_p0;
    logic                  in_rng_p0;
    logic [ENTRY_W-1:0]    entry_p1;
    logic                  vld_p1;

    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [ENTRY_W-1:0]    ram_wdata;
    logic                  wr_ok;
    logic                  par_bad;
    logic                  hit;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_X;
    endfunction

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic v,
                                                      input logic [DATA_WIDTH-1:0] d);
`ifdef ACM_LUT_PARITY_EN
        // Even parity: the stored bit makes the whole entry XOR to zero.
        return {^{v, d}, v, d};
`else
        return {v, d};
`endif
    endfunction

    always_ff @(posedge PCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            state   <= ST_INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= (state == ST_INIT) ? clr_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (clr_cnt == LAST_IDX) state_nxt = ST_IDLE;
            ST_IDLE: if (bus.LK_REQ)          state_nxt = ST_READ;
            ST_READ: state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_INIT;
        endcase
    end

    // Stage p0: capture the request address in IDLE; held through READ/RESP.
    always_ff @(posedge PCLK) begin
        if (state == ST_IDLE && bus.LK_REQ) begin
            lk_addr_p0 <= bus.LK_ADDR;
            in_rng_p0  <= in_range(bus.LK_ADDR);
        end
    end

    // The clear sequence owns the write port; user writes are dropped then.
    always_comb begin
        wr_ok     = bus.WR_EN && (state != ST_INIT) && in_range(bus.WR_ADDR);
        ram_we    = (state == ST_INIT) || wr_ok;
        ram_waddr = (state == ST_INIT) ? clr_cnt : bus.WR_ADDR;
        ram_wdata = (state == ST_INIT) ? '0 : pack_entry(bus.WR_VALID, bus.WR_DATA);
        ram_re    = (state == ST_READ) && in_rng_p0;
    end

    // Stage p1: entry registered by the RAM read in READ, presented in RESP.
    acm_lut_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .ENTRY_W    (ENTRY_W)
    ) u_ram (
        .PCLK  (PCLK),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (lk_addr_p0),
        .rdata (entry_p1)
    );

    always_comb begin
        vld_p1 = (state == ST_RESP);
`ifdef ACM_LUT_PARITY_EN
        par_bad = ^entry_p1;
`else
        par_bad = 1'b0;
`endif
        hit = vld_p1 && in_rng_p0 && entry_p1[DATA_WIDTH] && !par_bad;
    end

    assign bus.LK_ACK    = vld_p1;
    assign bus.LK_HIT    = hit;
    assign bus.LK_DATA   = hit ? entry_p1[DATA_WIDTH-1:0] : MISS_DATA;
    assign bus.INIT_BUSY = (state == ST_INIT);
`ifdef ACM_LUT_PARITY_EN
    assign bus.PAR_ERR   = vld_p1 && in_rng_p0 && par_bad;
`endif

endmodule

// File: tb/tb_acm_lut_engine.sv
// Bench for acm_lut_engine: a DEPTH=256 and a DEPTH=100 instance driven in
// lockstep and checked against a per-instance array model of the table.
module tb_acm_lut_engine;

    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int DEPTH_A = 256;
    localparam int DEPTH_B = 100;

    logic          PCLK = 1'b0;
    logic          NSYSRESET = 1'b0;
    logic          lk_req = 1'b0;
    logic [AW-1:0] lk_addr = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;

    always #5 PCLK = ~PCLK;

    acm_lut_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ia ();
    acm_lut_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ib ();

    assign ia.LK_REQ = lk_req;   assign ib.LK_REQ = lk_req;
    assign ia.LK_ADDR = lk_addr; assign ib.LK_ADDR = lk_addr;
    assign ia.WR_EN = wr_en;     assign ib.WR_EN = wr_en;
    assign ia.WR_ADDR = wr_addr; assign ib.WR_ADDR = wr_addr;
    assign ia.WR_DATA = wr_data; assign ib.WR_DATA = wr_data;
    assign ia.WR_VALID = wr_valid; assign ib.WR_VALID = wr_valid;

    acm_lut_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH_A)) dut_a (
        .PCLK(PCLK), .NSYSRESET(NSYSRESET), .bus(ia));
    acm_lut_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH_B)) dut_b (
        .PCLK(PCLK), .NSYSRESET(NSYSRESET), .bus(ib));

    // Reference table contents per instance.
    logic [DW-1:0] ref_d_a [256];
    logic [DW-1:0] ref_d_b [256];
    bit            ref_v_a [256];
    bit            ref_v_b [256];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  ack_a, ack_b;
        logic [DW:0] res_a, res_b;
        logic [DW:0] tail_a, tail_b;
        logic        pe_a;
    } lk_obs_t;

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) begin
            ref_d_a[i] = '0; ref_v_a[i] = 0;
            ref_d_b[i] = '0; ref_v_b[i] = 0;
        end
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic v);
        if (int'(a) < DEPTH_A) begin ref_d_a[a] = d; ref_v_a[a] = v; end
        if (int'(a) < DEPTH_B) begin ref_d_b[a] = d; ref_v_b[a] = v; end
    endtask

    function automatic logic [DW:0] expect_a(input logic [AW-1:0] a);
        if (int'(a) < DEPTH_A && ref_v_a[a]) return {1'b1, ref_d_a[a]};
        return '0;
    endfunction

    function automatic logic [DW:0] expect_b(input logic [AW-1:0] a);
        if (int'(a) < DEPTH_B && ref_v_b[a]) return {1'b1, ref_d_b[a]};
        return '0;
    endfunction

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic v);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_valid = v;
        model_write(a, d, v);
        step();
        wr_en = 1'b0;
    endtask

    // Issues one lookup from IDLE, optionally writing during the READ cycle.
    task automatic run_lookup(input logic [AW-1:0] a, input bit wr,
                              input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic wv, output lk_obs_t o);
        lk_req = 1'b1; lk_addr = a;
        step();
        lk_req = 1'b0;
        o.ack_a[2] = ia.LK_ACK; o.ack_b[2] = ib.LK_ACK;
        if (wr) begin
            wr_en = 1'b1; wr_addr = wa; wr_data = wd; wr_valid = wv;
            model_write(wa, wd, wv);
        end
        step();
        wr_en = 1'b0;
        o.ack_a[1] = ia.LK_ACK; o.ack_b[1] = ib.LK_ACK;
        o.res_a = {ia.LK_HIT, ia.LK_DATA}; o.res_b = {ib.LK_HIT, ib.LK_DATA};
`ifdef ACM_LUT_PARITY_EN
        o.pe_a = ia.PAR_ERR;
`else
        o.pe_a = 1'b0;
`endif
        step();
        o.ack_a[0] = ia.LK_ACK; o.ack_b[0] = ib.LK_ACK;
        o.tail_a = {ia.LK_HIT, ia.LK_DATA}; o.tail_b = {ib.LK_HIT, ib.LK_DATA};
    endtask

    task automatic test_reset();
        int busy_a, busy_b, acks;
        NSYSRESET = 1'b0;
        step(); step();
        n_cmp++;
        if ({ia.INIT_BUSY, ia.LK_ACK, ia.LK_HIT, ia.LK_DATA} !== {3'b100, 8'h00}) begin
            n_err++;
            $display("FAIL reset_state_a: busy/ack/hit/data=%b/%b/%b/%h need 1/0/0/00",
                     ia.INIT_BUSY, ia.LK_ACK, ia.LK_HIT, ia.LK_DATA);
        end
        n_cmp++;
        if ({ib.INIT_BUSY, ib.LK_ACK, ib.LK_HIT, ib.LK_DATA} !== {3'b100, 8'h00}) begin
            n_err++;
            $display("FAIL reset_state_b: busy/ack/hit/data=%b/%b/%b/%h need 1/0/0/00",
                     ib.INIT_BUSY, ib.LK_ACK, ib.LK_HIT, ib.LK_DATA);
        end
        NSYSRESET = 1'b1;
        model_clear();
        busy_a = 0; busy_b = 0; acks = 0;
        // Requests and writes during the clear must be ignored.
        for (int c = 0; c < 400 && (ia.INIT_BUSY || ib.INIT_BUSY); c++) begin
            if (ia.INIT_BUSY) busy_a++;
            if (ib.INIT_BUSY) busy_b++;
            if (ia.LK_ACK || ib.LK_ACK) acks++;
            if (c < 60) begin
                lk_req = 1'b1; lk_addr = 8'h05;
                wr_en = 1'b1; wr_addr = 8'h05; wr_data = 8'h77; wr_valid = 1'b1;
            end else begin
                lk_req = 1'b0; wr_en = 1'b0;
            end
            step();
        end
        lk_req = 1'b0; wr_en = 1'b0;
        n_cmp++;
        if (busy_a != DEPTH_A || ia.INIT_BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL init_len_a: busy cycles %0d now %b need %0d then 0", busy_a, ia.INIT_BUSY, DEPTH_A);
        end
        n_cmp++;
        if (busy_b != DEPTH_B || ib.INIT_BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL init_len_b: busy cycles %0d now %b need %0d then 0", busy_b, ib.INIT_BUSY, DEPTH_B);
        end
        n_cmp++;
        if (acks != 0) begin
            n_err++;
            $display("FAIL init_no_ack: saw %0d acks need 0", acks);
        end
    endtask

    task automatic test_spec_vectors();
        lk_obs_t o;
        logic [AW-1:0] addrs [4];
        addrs[0] = 8'h10; addrs[1] = 8'h05; addrs[2] = 8'h10; addrs[3] = 8'h64;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) do_write(8'h10, 8'hA5, 1'b1);
            if (i == 3) do_write(8'h64, 8'h55, 1'b1);
            run_lookup(addrs[i], 1'b0, '0, '0, 1'b0, o);
            n_cmp++;
            if ({o.ack_a, o.res_a, o.tail_a} !== {3'b010, expect_a(addrs[i]), 9'h0}) begin
                n_err++;
                $display("FAIL vec%0d_a addr %h: ack=%b res=%h tail=%h need ack=010 res=%h tail=000",
                         i, addrs[i], o.ack_a, o.res_a, o.tail_a, expect_a(addrs[i]));
            end
            n_cmp++;
            if ({o.ack_b, o.res_b, o.tail_b} !== {3'b010, expect_b(addrs[i]), 9'h0}) begin
                n_err++;
                $display("FAIL vec%0d_b addr %h: ack=%b res=%h tail=%h need ack=010 res=%h tail=000",
                         i, addrs[i], o.ack_b, o.res_b, o.tail_b, expect_b(addrs[i]));
            end
        end
    endtask

    task automatic test_bypass();
        lk_obs_t o;
        logic [DW-1:0] wd [2];
        logic          wv [2];
        wd[0] = 8'h3C; wv[0] = 1'b1;
        wd[1] = 8'h99; wv[1] = 1'b0;
        do_write(8'h20, 8'h11, 1'b0);
        for (int i = 0; i < 2; i++) begin
            run_lookup(8'h20, 1'b1, 8'h20, wd[i], wv[i], o);
            n_cmp++;
            if ({o.ack_a, o.res_a} !== {3'b010, expect_a(8'h20)}) begin
                n_err++;
                $display("FAIL bypass%0d_a: ack=%b res=%h need 010 %h", i, o.ack_a, o.res_a, expect_a(8'h20));
            end
            n_cmp++;
            if ({o.ack_b, o.res_b} !== {3'b010, expect_b(8'h20)}) begin
                n_err++;
                $display("FAIL bypass%0d_b: ack=%b res=%h need 010 %h", i, o.ack_b, o.res_b, expect_b(8'h20));
            end
        end
        do_write(8'h20, 8'h3C, 1'b1);
    endtask

    // With the request held high, a new address is accepted every third cycle.
    task automatic test_back_to_back();
        logic [AW-1:0] acc;
        logic [DW+1:0] exp_a, exp_b;
        acc = 8'h20;
        lk_req = 1'b1; lk_addr = acc;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_a = (k % 3 == 2) ? {1'b1, expect_a(acc)} : '0;
            exp_b = (k % 3 == 2) ? {1'b1, expect_b(acc)} : '0;
            n_cmp++;
            if ({ia.LK_ACK, ia.LK_HIT, ia.LK_DATA} !== exp_a) begin
                n_err++;
                $display("FAIL b2b_a cycle %0d: ack/hit/data=%b/%b/%h need %h",
                         k, ia.LK_ACK, ia.LK_HIT, ia.LK_DATA, exp_a);
            end
            n_cmp++;
            if ({ib.LK_ACK, ib.LK_HIT, ib.LK_DATA} !== exp_b) begin
                n_err++;
                $display("FAIL b2b_b cycle %0d: ack/hit/data=%b/%b/%h need %h",
                         k, ib.LK_ACK, ib.LK_HIT, ib.LK_DATA, exp_b);
            end
            if (k == 11) lk_req = 1'b0;
            if (k % 3 == 0) begin
                acc = ($urandom_range(0, 3) == 0) ? 8'h64 : AW'($urandom_range(0, 127));
                lk_addr = acc;
            end else begin
                lk_addr = AW'($urandom);
            end
        end
        lk_req = 1'b0;
    endtask

    task automatic test_random();
        lk_obs_t       o;
        logic [AW-1:0] a, wa;
        bit            wr;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_write(AW'($urandom_range(0, 140)), DW'($urandom), 1'($urandom_range(0, 3) != 0));
            end else begin
                a  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 140));
                wr = ($urandom_range(0, 2) == 0);
                wa = ($urandom_range(0, 1) == 0) ? a : AW'($urandom_range(0, 140));
                run_lookup(a, wr, wa, DW'($urandom), 1'($urandom_range(0, 1)), o);
                n_cmp++;
                if ({o.ack_a, o.res_a, o.tail_a} !== {3'b010, expect_a(a), 9'h0}) begin
                    n_err++;
                    $display("FAIL rand%0d_a addr %h: ack=%b res=%h tail=%h need 010 %h 000",
                             i, a, o.ack_a, o.res_a, o.tail_a, expect_a(a));
                end
                n_cmp++;
                if ({o.ack_b, o.res_b, o.tail_b} !== {3'b010, expect_b(a), 9'h0}) begin
                    n_err++;
                    $display("FAIL rand%0d_b addr %h: ack=%b res=%h tail=%h need 010 %h 000",
                             i, a, o.ack_b, o.res_b, o.tail_b, expect_b(a));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        lk_obs_t o;
        int      acks, busy_a;
        do_write(8'h10, 8'hA5, 1'b1);
        lk_req = 1'b1; lk_addr = 8'h10;
        step();
        lk_req = 1'b0;
        NSYSRESET = 1'b0;
        #1;
        n_cmp++;
        if ({ia.LK_ACK, ia.INIT_BUSY, ib.LK_ACK, ib.INIT_BUSY} !== 4'b0101) begin
            n_err++;
            $display("FAIL mid_reset_state: ack_a/busy_a/ack_b/busy_b=%b%b%b%b need 0101",
                     ia.LK_ACK, ia.INIT_BUSY, ib.LK_ACK, ib.INIT_BUSY);
        end
        step();
        NSYSRESET = 1'b1;
        model_clear();
        acks = 0; busy_a = 0;
        for (int c = 0; c < 400 && (ia.INIT_BUSY || ib.INIT_BUSY); c++) begin
            if (ia.LK_ACK || ib.LK_ACK) acks++;
            if (ia.INIT_BUSY) busy_a++;
            step();
        end
        n_cmp++;
        if (acks != 0 || busy_a != DEPTH_A || ia.INIT_BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_rerun: acks=%0d busy=%0d need 0 acks and %0d busy", acks, busy_a, DEPTH_A);
        end
        run_lookup(8'h10, 1'b0, '0, '0, 1'b0, o);
        n_cmp++;
        if ({o.ack_a, o.res_a, o.ack_b, o.res_b} !== {3'b010, 9'h0, 3'b010, 9'h0}) begin
            n_err++;
            $display("FAIL mid_reset_cleared: ack_a=%b res_a=%h ack_b=%b res_b=%h need 010 000 010 000",
                     o.ack_a, o.res_a, o.ack_b, o.res_b);
        end
    endtask

`ifdef ACM_LUT_PARITY_EN
    task automatic test_parity();
        lk_obs_t o;
        do_write(8'h10, 8'hA5, 1'b1);
        dut_a.u_ram.mem[16] = dut_a.u_ram.mem[16] ^ 10'h001;
        run_lookup(8'h10, 1'b0, '0, '0, 1'b0, o);
        n_cmp++;
        if ({o.ack_a, o.pe_a, o.res_a} !== {3'b010, 1'b1, 9'h0}) begin
            n_err++;
            $display("FAIL parity_err: ack=%b par_err=%b res=%h need 010 1 000", o.ack_a, o.pe_a, o.res_a);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_spec_vectors();
        test_bypass();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef ACM_LUT_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/acm_lut_engine.md
ACM_LUT_ENGINE -- requirements
Module: acm_lut_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: width of lookup and write addresses.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: width of table entry data.
REQ-003 SHALL have parameter DEPTH, default 256: number of table entries, 1 <= DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL have port PCLK, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port NSYSRESET, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port LK_REQ, input, 1: lookup request.
REQ-007 SHALL have port LK_ADDR, input, ADDR_WIDTH: lookup address.
REQ-008 SHALL have port LK_ACK, output, 1: one-cycle lookup-complete strobe.
REQ-009 SHALL have port LK_DATA, output, DATA_WIDTH: lookup result, valid while LK_ACK=1.
REQ-010 SHALL have port LK_HIT, output, 1: entry valid flag, valid while LK_ACK=1.
REQ-011 SHALL have port WR_EN, input, 1: table write strobe.
REQ-012 SHALL have port WR_ADDR, input, ADDR_WIDTH: write address.
REQ-013 SHALL have port WR_DATA, input, DATA_WIDTH: write data.
REQ-014 SHALL have port WR_VALID, input, 1: valid bit stored with the entry; 0 invalidates it.
REQ-015 SHALL have port INIT_BUSY, output, 1: high while the table clear sequence runs.

Function
REQ-016 SHALL implement FSM states INIT, IDLE, READ, RESP.
REQ-017 INIT: SHALL clear one entry per cycle, counter 0..DEPTH-1; SHALL go to IDLE after entry DEPTH-1; SHALL hold INIT_BUSY=1 throughout.
REQ-018 IDLE: LK_REQ=1 SHALL capture LK_ADDR and go to READ; otherwise stay.
REQ-019 READ: SHALL read the entry registered in IDLE and go to RESP.
REQ-020 RESP: SHALL drive LK_ACK=1 for exactly one cycle with LK_DATA/LK_HIT, then go to IDLE; latency is LK_REQ sample to LK_ACK = 2 cycles.
REQ-021 A miss (entry valid bit 0, or captured address >= DEPTH) SHALL return LK_HIT=0 and LK_DATA=0, never X.
REQ-022 LK_REQ is ignored outside IDLE; a request held high through RESP SHALL be re-accepted on the following IDLE cycle.
REQ-023 Writes with WR_EN=1 in IDLE, READ or RESP SHALL update the entry in one cycle; writes with WR_ADDR >= DEPTH SHALL be dropped.
REQ-024 Writes during INIT SHALL be dropped.
REQ-025 A write and READ to the same address in the same cycle SHALL return the new WR_DATA/WR_VALID (write-first bypass).
REQ-026 LK_DATA and LK_HIT SHALL be 0 whenever LK_ACK=0.

Reset
REQ-027 Reset asserted SHALL force state INIT, counter 0, LK_ACK=0, LK_DATA=0, LK_HIT=0, INIT_BUSY=1.
REQ-028 Reset mid-lookup SHALL abort it with no LK_ACK, then re-run the full INIT clear.

Configuration
REQ-029 With ACM_LUT_PARITY_EN defined: each entry SHALL store an even-parity bit over {valid,data}; output port PAR_ERR (1 bit, reset 0) SHALL pulse with LK_ACK on mismatch, forcing LK_HIT=0 and LK_DATA=0.
REQ-030 Without ACM_LUT_PARITY_EN: no parity storage, no PAR_ERR port.

Structure
REQ-031 FSM state encoding and miss-data constant SHALL live in shared package acm_lut_pkg.
REQ-032 Storage SHALL be sub-module acm_lut_ram: one write port, one synchronous read port, entry width DATA_WIDTH+1 (+1 with parity).

Verification
REQ-033 Release reset, DEPTH=256: INIT_BUSY high 256 cycles, then 0; lookup addr 0x10 -> LK_HIT=0, LK_DATA=0x00.
REQ-034 Write 0x10<-0xA5 valid=1; LK_REQ addr 0x10 at cycle t -> LK_ACK at t+2, LK_DATA=0xA5, LK_HIT=1.
REQ-035 DEPTH=100: write 0x64<-0x55 and look up 0x64 -> write dropped, LK_HIT=0, LK_DATA=0x00.
REQ-036 Write 0x20<-0x3C in same cycle as READ of 0x20 -> LK_DATA=0x3C, LK_HIT=1; LK_REQ held high -> acks every 3 cycles.
REQ-037 Assert NSYSRESET in READ -> no LK_ACK, INIT reruns, earlier entry 0x10 reads LK_HIT=0.
REQ-038 ACM_LUT_PARITY_EN: force flipped data bit in entry 0x10 -> PAR_ERR=1 with LK_ACK, LK_HIT=0, LK_DATA=0x00.
